// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush beats push and pop, and only
// control state is reset while the entry storage is left as data.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_pop;
  logic            w_push;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a small decoupling queue and redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fault and halt fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  logic [31:0]  r_pc;
  logic         w_halt;
  logic         w_load_pc;
  logic [31:0]  w_target;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  fetch_entry_t w_head;
  fetch_entry_t w_new;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;
  logic w_misaligned;

  assign w_misaligned = |redirect_pc[1:0];
  assign w_target     = redirect_pc;
  assign w_load_pc    = !w_misaligned;
  assign w_halt       = r_fault;
  assign fetch_fault  = r_fault;

  // Fault is re-evaluated on every redirect, so an aligned one clears it.
  always_ff @(posedge clk) begin
    if (rst)                 r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= w_misaligned;
  end
`else
  assign w_target    = redirect_pc & ~32'h0000_0003;
  assign w_load_pc   = 1'b1;
  assign w_halt      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign w_pop     = !w_empty && out_ready && !redirect_valid;
  assign w_push    = !redirect_valid && !w_halt && (!w_full || w_pop);
  assign w_new     = '{pc: r_pc, instr: imem_instr};

  // Zero the visible head when empty so reset and flush leave clean outputs.
  assign out_instr = w_empty ? 32'h0 : w_head.instr;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;

  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= w_load_pc ? w_target : r_pc;
    else if (w_push)         r_pc <= r_pc + PC_STEP;
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redirect_valid),
    .i_data (w_new),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random stimulus for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam int          D    = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc   = RPC;
  logic        mfault = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_unit #(
    .RESET_PC   (RPC),
    .QUEUE_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour per clock edge, written from the fetch rules directly.
  task automatic model_edge(input logic r, input logic v, input logic [31:0] p, input logic rdy);
    logic pop;
    logic push;
    if (r) begin
      mq.delete();
      mpc    = RPC;
      mfault = 1'b0;
    end else if (v) begin
      mq.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (p[1:0] != 2'b00) mfault = 1'b1;
      else begin
        mfault = 1'b0;
        mpc    = p;
      end
`else
      mpc = {p[31:2], 2'b00};
`endif
    end else begin
      pop  = (mq.size() > 0) && rdy;
      push = !mfault && ((mq.size() < D) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] h;
    h = (mq.size() > 0) ? mq[0] : 64'h0;
    chk("imem_addr", imem_addr, mpc);
    chk("out_valid", {31'h0, out_valid}, {31'h0, mq.size() > 0});
    chk("out_pc", out_pc, h[63:32]);
    chk("out_instr", out_instr, h[31:0]);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, mfault});
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] p, input logic rdy);
    rst            = r;
    redirect_valid = v;
    redirect_pc    = p;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(r, v, p, rdy);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic r, v, rdy;
    logic [31:0] p;

    // Reset, then streaming with out_ready held high.
    step(1, 0, 0, 1);
    step(1, 1, 32'h0000_0040, 1);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    step(0, 0, 0, 1);
    chk("seq_pc0", out_pc, 32'h0);
    chk("seq_in0", out_instr, mem_word(32'h0));
    step(0, 0, 0, 1);
    chk("seq_pc1", out_pc, 32'h4);
    chk("seq_in1", out_instr, mem_word(32'h4));
    step(0, 0, 0, 1);
    chk("seq_pc2", out_pc, 32'h8);
    chk("seq_in2", out_instr, mem_word(32'h8));

    // Backpressure from a fresh reset.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);

    // Redirect while full.
    step(0, 1, 32'h0000_0040, 0);
    chk("rd_gap", {31'h0, out_valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("rd_pc0", out_pc, 32'h40);
    step(0, 0, 0, 1);
    chk("rd_pc1", out_pc, 32'h44);

    // Redirect coinciding with a pop.
    step(0, 1, 32'h0000_0100, 1);
    chk("rdpop_gap", {31'h0, out_valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("rdpop_pc", out_pc, 32'h100);

    // Back-to-back redirects: only the last target appears.
    step(0, 1, 32'h0000_0200, 1);
    step(0, 1, 32'h0000_0300, 1);
    step(0, 0, 0, 1);
    chk("b2b_pc", out_pc, 32'h300);

    // Wrap-around.
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc1", out_pc, 32'h0);

    // Misaligned redirect.
    step(0, 1, 32'h0000_0042, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_valid", {31'h0, out_valid}, 32'h0);
    step(0, 1, 32'h0000_0080, 1);
    chk("mis_clear", {31'h0, fetch_fault}, 32'h0);
    step(0, 0, 0, 1);
    chk("mis_resume", out_pc, 32'h80);
`else
    step(0, 0, 0, 1);
    chk("mis_pc", out_pc, 32'h40);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h0);
`endif

    // Mid-stream reset discards queued entries.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_addr", imem_addr, RPC);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(63) == 0);
      v   = ($urandom_range(7) == 0);
      rdy = $urandom_range(1);
      case ($urandom_range(3))
        0:       p = 32'hFFFF_FFF0 | ($urandom_range(15) & 32'hC);
        1:       p = $urandom;
        default: p = $urandom & 32'h0000_0FFC;
      endcase
      step(r, v, p, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2: entries in the fetch queue; legal values 2 or 4.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32: byte address to instruction memory; word-aligned.
REQ-006 SHALL have port imem_instr, input, 32: instruction returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32: redirect target byte address.
REQ-009 SHALL have port out_valid, output, 1: queue head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1: decoder accepts the head this cycle.
REQ-011 SHALL have port out_instr, output, 32: instruction at queue head.
REQ-012 SHALL have port out_pc, output, 32: byte address of out_instr.
REQ-013 SHALL have port fetch_fault, output, 1: misaligned redirect flag (see Configuration).

Function
REQ-014 SHALL drive imem_addr = pc register at all times.
REQ-015 SHALL push {pc, imem_instr} and advance pc by 4 on a rising edge when no redirect is active, fetch is not halted, and the queue is not full, or is full with a pop in the same cycle.
REQ-016 SHALL hold pc and push nothing when the queue is full and out_ready is low.
REQ-017 SHALL pop the head on a rising edge when out_valid and out_ready are both high.
REQ-018 SHALL support simultaneous push and pop in one cycle, with the count unchanged.
REQ-019 SHALL wrap pc modulo 2^32, so that 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-020 SHALL make out_valid a function of queue occupancy only, with no combinational path from out_ready or imem_instr.
REQ-021 SHALL keep out_instr and out_pc stable while out_valid is high and out_ready is low.
REQ-022 SHALL, on redirect_valid high, flush all queue entries, load pc with redirect_pc, push nothing and ignore out_ready that cycle.
REQ-023 SHALL hold out_valid low in the cycle after a redirect and present the target instruction one cycle later, a redirect-to-valid latency of 2 cycles.
REQ-024 SHALL give redirect priority over push, pop and stall.
REQ-025 SHALL handle back-to-back redirects so that the last one wins and no intermediate target reaches the output.

Reset
REQ-026 SHALL, with rst high at a rising edge, set pc=RESET_PC, empty the queue, set out_valid=0, out_instr=0, out_pc=0 and fetch_fault=0.
REQ-027 SHALL give rst priority over redirect_valid and out_ready.
REQ-028 SHALL discard all queued entries when rst is asserted mid-stream.
REQ-029 SHALL, in the first cycle after rst deasserts, drive imem_addr=RESET_PC with out_valid=0, then assert out_valid on the next cycle.

Configuration
REQ-030 SHALL, with FETCH_MISALIGN_CHECK_EN defined, set fetch_fault sticky and halt fetching on a redirect with redirect_pc[1:0]!=0, with the queue flushed and pc unchanged.
REQ-031 SHALL, with FETCH_MISALIGN_CHECK_EN defined, clear fetch_fault and resume fetching only on rst or on a later aligned redirect.
REQ-032 SHALL, without FETCH_MISALIGN_CHECK_EN, load {redirect_pc[31:2],2'b00}, tie fetch_fault to 0 and never halt fetching.

Structure
REQ-033 SHALL place in package fetch_pkg: typedef fetch_entry_t {pc[31:0], instr[31:0]}, constant INSTR_BYTES=4 and the default reset PC constant.
REQ-034 SHALL implement the queue as sub-module fetch_queue: a synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty, and flush taking priority over push.

Verification
REQ-035 SHALL verify reset: RESET_PC=0, out_ready=1 held -> out_pc sequence 0x0,0x4,0x8 on consecutive cycles, with out_instr matching memory words 0,1,2.
REQ-036 SHALL verify backpressure: out_ready=0 for 5 cycles -> the queue fills to QUEUE_DEPTH, imem_addr freezes at 0x8 (depth 2), and out_pc stays 0x0.
REQ-037 SHALL verify redirect: redirect_pc=0x40 while the queue is full -> out_valid=0 for one cycle, then out_pc=0x40, 0x44, with no stale entry emitted.
REQ-038 SHALL verify a redirect coinciding with a pop: redirect and out_ready both high -> the pop is discarded and the next emitted out_pc equals the redirect target.
REQ-039 SHALL verify wrap-around: redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC followed by 0x0000_0000.
REQ-040 SHALL verify misalignment: redirect_pc=0x42 -> with the macro, fetch_fault=1, out_valid stays 0, and an aligned redirect to 0x80 clears the fault; without the macro, out_pc=0x40.
